// File: rtl/fir_coeff_load_ctrl.sv
// FIR coefficient load sequencer: gates host SRAM writes, replays SRAM
// into the coefficient bank, zero-fills unused taps, then enables the MAC.
module fir_coeff_load_ctrl #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 33,
  parameter int ADDR_W = 6
) (
  input  logic              iClk_12M,
  input  logic              iRst,
  input  logic              iCoeffUpdateFlag,
  input  logic              iCsnRam,
  input  logic              iWrnRam,
  input  logic [ADDR_W-1:0] iAddrRam,
  input  logic [DATA_W-1:0] iWrDtRam,
  input  logic [ADDR_W-1:0] iNumOfCoeff,
  input  logic [DATA_W-1:0] iRdDtRam,
  output logic              oCsnRam,
  output logic              oWrnRam,
  output logic [ADDR_W-1:0] oAddrRam,
  output logic [DATA_W-1:0] oWrDtRam,
  output logic              oCoeffWe,
  output logic [ADDR_W-1:0] oCoeffIdx,
  output logic [DATA_W-1:0] oCoeffDt,
  output logic              oEnDelay,
  output logic              oEnAcc,
  output logic              oBusy,
  output logic              oLoadDone
);

  typedef enum logic [2:0] {
    S_IDLE, S_UPDATE, S_LOAD, S_FLUSH, S_CLEAR, S_RUN
  } state_e;

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

  state_e              state_q, state_d;
  logic                csn_q, csn_d, wrn_q, wrn_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdt_q, wdt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]   dt_q, dt_d;
  logic                en_q, en_d, busy_q, busy_d, done_q, done_d;
  logic [ADDR_W-1:0]   num_q, num_d, clr_q, clr_d, pidx_q, pidx_d;
  logic                pend_q, pend_d;
  logic [ADDR_W-1:0]   num_eff;

  assign num_eff = (iNumOfCoeff > DEPTH_A) ? DEPTH_A : iNumOfCoeff;

  always_comb begin
    state_d = state_q;
    csn_d   = 1'b1;
    wrn_d   = 1'b1;
    addr_d  = addr_q;
    wdt_d   = wdt_q;
    we_d    = 1'b0;
    idx_d   = idx_q;
    dt_d    = dt_q;
    num_d   = num_q;
    clr_d   = clr_q;
    pidx_d  = pidx_q;
    pend_d  = 1'b0;
    // A read issued last cycle has its data on iRdDtRam now
    if (pend_q && !iCoeffUpdateFlag) begin
      we_d  = 1'b1;
      idx_d = pidx_q;
      dt_d  = iRdDtRam;
    end
    unique case (state_q)
      S_IDLE: begin
        if (iCoeffUpdateFlag) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        if (iCoeffUpdateFlag) begin
          csn_d  = iCsnRam | (iAddrRam >= DEPTH_A);
          wrn_d  = iWrnRam;
          addr_d = iAddrRam;
          wdt_d  = iWrDtRam;
        end else begin
          num_d = num_eff;
          clr_d = num_eff;
          if (num_eff == '0) begin
            state_d = S_CLEAR;
          end else begin
            state_d = S_LOAD;
            csn_d   = 1'b0;
            addr_d  = '0;
          end
        end
      end
      S_LOAD: begin
        if (iCoeffUpdateFlag) begin
          state_d = S_UPDATE;
          addr_d  = '0;
          clr_d   = '0;
          pidx_d  = '0;
        end else begin
          pend_d = 1'b1;
          pidx_d = addr_q;
          if (addr_q == num_q - ADDR_W'(1)) begin
            state_d = S_FLUSH;
          end else begin
            csn_d  = 1'b0;
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      S_FLUSH: begin
        if (iCoeffUpdateFlag) begin
          state_d = S_UPDATE;
          clr_d   = '0;
          pidx_d  = '0;
        end else if (num_q == DEPTH_A) begin
          state_d = S_RUN;
        end else begin
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (iCoeffUpdateFlag) begin
          state_d = S_UPDATE;
          clr_d   = '0;
        end else begin
          we_d  = 1'b1;
          idx_d = clr_q;
          dt_d  = '0;
          if (clr_q == LAST_A) state_d = S_RUN;
          else clr_d = clr_q + ADDR_W'(1);
        end
      end
      S_RUN: begin
        if (iCoeffUpdateFlag) state_d = S_UPDATE;
      end
      default: state_d = S_IDLE;
    endcase
    en_d   = (state_d == S_RUN);
    done_d = (state_d == S_RUN) && (state_q != S_RUN);
    busy_d = (state_d == S_UPDATE) || (state_d == S_LOAD) ||
             (state_d == S_FLUSH) || (state_d == S_CLEAR);
  end

  always_ff @(posedge iClk_12M) begin
    if (iRst) begin
      state_q <= S_IDLE;
      csn_q   <= 1'b1;
      wrn_q   <= 1'b1;
      addr_q  <= '0;
      wdt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      dt_q    <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      num_q   <= '0;
      clr_q   <= '0;
      pidx_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      csn_q   <= csn_d;
      wrn_q   <= wrn_d;
      addr_q  <= addr_d;
      wdt_q   <= wdt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      dt_q    <= dt_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      num_q   <= num_d;
      clr_q   <= clr_d;
      pidx_q  <= pidx_d;
      pend_q  <= pend_d;
    end
  end

  assign oCsnRam   = csn_q;
  assign oWrnRam   = wrn_q;
  assign oAddrRam  = addr_q;
  assign oWrDtRam  = wdt_q;
  assign oCoeffWe  = we_q;
  assign oCoeffIdx = idx_q;
  assign oCoeffDt  = dt_q;
  assign oEnDelay  = en_q;
  assign oEnAcc    = en_q;
  assign oBusy     = busy_q;
  assign oLoadDone = done_q;

endmodule

// File: tb/tb_fir_coeff_load_ctrl.sv
// Bench for fir_coeff_load_ctrl: SRAM model, timeline model of the
// coefficient load, per-cycle compare and directed scenarios.
module tb_fir_coeff_load_ctrl;
  localparam int DW = 16;
  localparam int DP = 33;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          iRst, iFlag, iCsn, iWrn;
  logic [AW-1:0] iAddr, iNum;
  logic [DW-1:0] iWdt, iRdDt;
  logic          oCsn, oWrn, oWe, oEnD, oEnA, oBusy, oDone;
  logic [AW-1:0] oAddr, oIdx;
  logic [DW-1:0] oWdt, oDt;

  fir_coeff_load_ctrl #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW)) dut (
    .iClk_12M(clk), .iRst(iRst), .iCoeffUpdateFlag(iFlag),
    .iCsnRam(iCsn), .iWrnRam(iWrn), .iAddrRam(iAddr), .iWrDtRam(iWdt),
    .iNumOfCoeff(iNum), .iRdDtRam(iRdDt),
    .oCsnRam(oCsn), .oWrnRam(oWrn), .oAddrRam(oAddr), .oWrDtRam(oWdt),
    .oCoeffWe(oWe), .oCoeffIdx(oIdx), .oCoeffDt(oDt),
    .oEnDelay(oEnD), .oEnAcc(oEnA), .oBusy(oBusy), .oLoadDone(oDone)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle", nm, act, exp);
    end
  endtask

  // single-port SRAM, registered read
  logic [DW-1:0] sram [64];
  logic [DW-1:0] rd_q = '0;
  assign iRdDt = rd_q;
  always @(posedge clk) begin
    if (oCsn === 1'b0) begin
      if (oWrn === 1'b0) sram[oAddr] <= oWdt;
      else rd_q <= sram[oAddr];
    end
  end

  // timeline model: where each output must be relative to the load start
  logic [DW-1:0] ref_mem [DP];
  int   cyc  = 0;
  int   mode = 0;
  int   ls   = -1;
  int   n    = 0;
  bit   fwd_v;
  logic fwd_csn, fwd_wrn;
  logic [AW-1:0] fwd_addr;
  logic [DW-1:0] fwd_wdt;

  function automatic int clamp_n(input int x);
    if (x > DP) return DP;
    return x;
  endfunction

  always @(posedge clk) begin
    fwd_v = 1'b0;
    if (iRst) begin
      mode = 0;
      ls   = -1;
    end else begin
      case (mode)
        0: if (iFlag) mode = 1;
        1: begin
          if (iFlag) begin
            fwd_v    = 1'b1;
            fwd_csn  = iCsn | (int'(iAddr) >= DP);
            fwd_wrn  = iWrn;
            fwd_addr = iAddr;
            fwd_wdt  = iWdt;
            if (!iCsn && !iWrn && int'(iAddr) < DP) ref_mem[iAddr] = iWdt;
          end else begin
            n    = clamp_n(int'(iNum));
            ls   = cyc + 1;
            mode = 2;
          end
        end
        default: if (iFlag) begin
          mode = 1;
          ls   = -1;
        end
      endcase
    end
    cyc = cyc + 1;
  end

  bit chk_en = 1'b0;
  logic [DW-1:0] bank [DP];
  int we_cnt = 0;

  always @(negedge clk) begin
    int off, first, runoff, ix;
    bit e_we, e_run, e_done, e_busy;
    logic e_csn;
    if (oWe === 1'b1 && int'(oIdx) < DP) begin
      bank[oIdx] = oDt;
      we_cnt++;
    end
    if (chk_en) begin
      off    = cyc - ls;
      first  = (n > 0) ? 2 : 1;
      runoff = first + 32;
      e_we   = (ls >= 0) && off >= first && off < first + DP;
      e_run  = (ls >= 0) && off >= runoff;
      e_done = (ls >= 0) && off == runoff;
      e_busy = (mode == 1) || ((ls >= 0) && off < runoff);
      e_csn  = 1'b1;
      if (fwd_v) e_csn = fwd_csn;
      else if (ls >= 0 && n > 0 && off >= 0 && off < n) e_csn = 1'b0;
      chk("we", oWe, e_we);
      if (e_we) begin
        ix = off - first;
        chk("idx", oIdx, ix);
        chk("dt", oDt, (ix < n) ? ref_mem[ix] : 16'h0);
      end
      chk("en_delay", oEnD, e_run);
      chk("en_acc", oEnA, e_run);
      chk("load_done", oDone, e_done);
      chk("busy", oBusy, e_busy);
      chk("csn", oCsn, e_csn);
      if (e_csn == 1'b0) begin
        if (fwd_v) begin
          chk("fwd_wrn", oWrn, fwd_wrn);
          chk("fwd_addr", oAddr, fwd_addr);
          if (!fwd_wrn) chk("fwd_wdt", oWdt, fwd_wdt);
        end else begin
          chk("rd_wrn", oWrn, 1'b1);
          chk("rd_addr", oAddr, off);
        end
      end
    end
  end

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic host(input logic wr, input int a, input logic [DW-1:0] d);
    iCsn  = 1'b0;
    iWrn  = ~wr;
    iAddr = AW'(a);
    iWdt  = d;
    step(1);
    iCsn = 1'b1;
    iWrn = 1'b1;
  endtask

  // closes the update window and returns cycles from flag fall to done
  task automatic run_load(input int num, output int lat);
    int t0;
    bit seen;
    iNum   = AW'(num);
    we_cnt = 0;
    iFlag  = 1'b0;
    step(1);
    t0   = cyc;
    seen = 1'b0;
    lat  = -1;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (oDone === 1'b1) begin
        seen = 1'b1;
        lat  = cyc - t0;
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
    step(1);
  endtask

  initial begin
    int lat, snap;
    for (int i = 0; i < 64; i++) sram[i] = '0;
    for (int i = 0; i < DP; i++) begin
      ref_mem[i] = '0;
      bank[i]    = '0;
    end
    iRst = 1'b1; iFlag = 1'b0; iCsn = 1'b1; iWrn = 1'b1;
    iAddr = '0; iWdt = '0; iNum = '0;
    step(3);
    iRst   = 1'b0;
    chk_en = 1'b1;
    step(10);
    chk("rst_csn", oCsn, 1'b1);
    chk("rst_wrn", oWrn, 1'b1);
    chk("rst_addr", oAddr, 0);
    chk("rst_idx", oIdx, 0);
    chk("rst_dt", oDt, 0);

    // full 33-tap load with an out-of-range write and a host read
    iFlag = 1'b1;
    step(1);
    for (int k = 0; k < DP; k++) host(1'b1, k, 16'h0100 + 16'(k));
    host(1'b1, 40, 16'hDEAD);
    host(1'b0, 2, 16'h0);
    step(1);
    run_load(33, lat);
    chk("lat_33", lat, 34);
    chk("wecnt_33", we_cnt, 33);
    chk("bank5_33", bank[5], 16'h0105);
    chk("bank32_33", bank[32], 16'h0120);
    step(3);
    chk("run_enacc", oEnA, 1'b1);
    host(1'b1, 3, 16'hFFFF);
    step(2);
    chk("run_wr_blocked", sram[3], 16'h0103);

    // partial load, zero-filled tail
    iFlag = 1'b1;
    step(2);
    run_load(10, lat);
    chk("lat_10", lat, 34);
    chk("wecnt_10", we_cnt, 33);
    chk("bank9_10", bank[9], 16'h0109);
    chk("bank10_10", bank[10], 16'h0);
    chk("bank32_10", bank[32], 16'h0);
    step(2);

    // zero taps: clear only
    iFlag = 1'b1;
    step(2);
    run_load(0, lat);
    chk("lat_0", lat, 33);
    chk("wecnt_0", we_cnt, 33);
    chk("bank0_0", bank[0], 16'h0);
    step(2);

    // oversized count clamps to full load
    iFlag = 1'b1;
    step(2);
    run_load(45, lat);
    chk("lat_45", lat, 34);
    chk("wecnt_45", we_cnt, 33);
    chk("bank0_45", bank[0], 16'h0100);
    chk("bank32_45", bank[32], 16'h0120);
    step(2);

    // abort at load cycle 5
    iFlag = 1'b1;
    step(2);
    iNum   = AW'(10);
    we_cnt = 0;
    iFlag  = 1'b0;
    step(1);
    step(5);
    iFlag = 1'b1;
    step(1);
    snap = we_cnt;
    chk("abort_wecnt", snap, 4);
    step(10);
    chk("abort_no_we", we_cnt, snap);
    chk("abort_enacc", oEnA, 1'b0);
    chk("abort_busy", oBusy, 1'b1);

    // reset in the middle of CLEAR
    iFlag = 1'b0;
    step(1);
    step(14);
    iRst = 1'b1;
    step(1);
    iRst = 1'b0;
    chk("crst_we", oWe, 1'b0);
    chk("crst_busy", oBusy, 1'b0);
    chk("crst_idx", oIdx, 0);
    chk("crst_dt", oDt, 0);
    chk("crst_csn", oCsn, 1'b1);
    chk("crst_en", oEnD, 1'b0);
    step(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fir_coeff_load_ctrl.md
Name: fir_coeff_load_ctrl

Overview:
- Sequencer between the host coefficient bus, the 16-bit coefficient single-port SRAM and the transposed FIR coefficient register bank.
- Owns the SRAM port. Gates host writes during the update window, then replays SRAM contents into the coefficient bank and zero-fills the unused taps.
- Releases the MAC/shift datapath (oEnDelay/oEnAcc) only after a complete, consistent coefficient set is in place.

Parameters:
DATA_W, 16, coefficient width
DEPTH, 33, number of taps / SRAM words
ADDR_W, 6, address and index width

Ports:
iClk_12M  in  1  system clock, rising edge
iRst  in  1  synchronous reset, active-high
iCoeffUpdateFlag  in  1  high = host coefficient update window
iCsnRam  in  1  host chip select, active-low
iWrnRam  in  1  host write strobe, active-low (0 = write)
iAddrRam  in  ADDR_W  host word address
iWrDtRam  in  DATA_W  host write data
iNumOfCoeff  in  ADDR_W  active tap count
iRdDtRam  in  DATA_W  SRAM read data, valid 1 cycle after read
oCsnRam  out  1  SRAM chip select, active-low
oWrnRam  out  1  SRAM write strobe, active-low
oAddrRam  out  ADDR_W  SRAM address
oWrDtRam  out  DATA_W  SRAM write data
oCoeffWe  out  1  coefficient bank write strobe
oCoeffIdx  out  ADDR_W  bank index, 0..DEPTH-1
oCoeffDt  out  DATA_W  bank write data
oEnDelay  out  1  datapath shift enable
oEnAcc  out  1  datapath accumulate enable
oBusy  out  1  high in UPDATE/LOAD/FLUSH/CLEAR
oLoadDone  out  1  1-cycle pulse on entry to RUN

Behaviour:
- Reset, applied at any clock edge in any state:
  - State = IDLE.
  - oCsnRam=1, oWrnRam=1; oAddrRam, oWrDtRam, oCoeffIdx, oCoeffDt = 0.
  - oCoeffWe, oEnDelay, oEnAcc, oBusy, oLoadDone = 0.
  - Counters cleared; any read in flight is discarded.
- States: IDLE, UPDATE, LOAD, FLUSH, CLEAR, RUN. All outputs are registered.
- IDLE:
  - Datapath disabled; SRAM idle.
  - iCoeffUpdateFlag=1 -> UPDATE.
- UPDATE:
  - Host bus forwarded to the SRAM with 1-cycle register delay (oCsnRam/oWrnRam/oAddrRam/oWrDtRam <= host values).
  - Accesses with iAddrRam>=DEPTH are dropped: oCsnRam forced to 1.
  - Host reads are forwarded, but their data is not consumed.
  - Datapath disabled.
  - Flag=0 -> LOAD. On that edge NumEff is latched: iNumOfCoeff if 1..DEPTH; DEPTH if >DEPTH; 0 if 0.
- Host bus outside UPDATE: ignored, never reaches the SRAM.
- LOAD (read address rA, 0 to NumEff-1, one per cycle):
  - oCsnRam=0, oWrnRam=1, oAddrRam=rA.
  - One cycle after each read: oCoeffWe=1, oCoeffIdx=previous rA, oCoeffDt=iRdDtRam.
  - After address NumEff-1 is issued -> FLUSH. NumEff=0 skips LOAD and goes directly to CLEAR.
- FLUSH:
  - 1 cycle; SRAM idle.
  - Captures the last read word (idx NumEff-1) into the bank.
  - -> CLEAR.
- CLEAR:
  - Writes oCoeffDt=0 to idx NumEff..DEPTH-1, one per cycle.
  - If NumEff=DEPTH: 0 cycles, go directly to RUN.
- Load latency: LOAD entry at cycle T gives the last bank write at T+DEPTH and RUN at T+DEPTH+1, for any NumEff.
- RUN:
  - oEnDelay=oEnAcc=1; oLoadDone pulses on the first RUN cycle.
  - Flag=1 -> UPDATE; enables drop the following cycle.
- Flag=1 during LOAD, FLUSH or CLEAR:
  - Abort to UPDATE. Pending bank write discarded, counters cleared.
  - Bank is left partially loaded; datapath stays disabled until a full pass completes.
- Index wrap: counters never exceed DEPTH-1. oCoeffIdx>=DEPTH never occurs.
- oBusy = (state is UPDATE, LOAD, FLUSH or CLEAR).

Test Plan:
1. Reset then idle, flag=0 for 10 cycles -> all outputs 0, oCsnRam=oWrnRam=1, state IDLE.
2. Flag=1; host writes addr k data 16'h0100+k for k=0..32; flag=0; iNumOfCoeff=33 -> 33 oCoeffWe pulses, idx k with data 16'h0100+k in order. oLoadDone and oEnAcc go high at flag-fall+34 cycles.
3. Same contents, iNumOfCoeff=10 -> idx 0..9 carry 16'h0100..16'h0109, idx 10..32 written 0, RUN at the same +34 cycles.
4. iNumOfCoeff=0 and separately 45 -> 0: 33 zero writes; 45: clamped to 33, identical to scenario 2.
5. Host write to addr 40 in UPDATE -> oCsnRam stays 1. Host write in RUN -> no SRAM access.
6. Flag reasserted at LOAD cycle 5 -> abort to UPDATE, no further oCoeffWe, oEnAcc=0. iRst pulsed in CLEAR -> IDLE, all outputs at reset values next cycle.
